iar_stack: RTL and testbench
============================

// Module: iar_stack
// PURPOSE
//  Parametrised interrupt-address-register stack: next generation of the single IAR.
//  Saves the restart PC (and the pre-exception user/supervisor mode) on every exception, supporting nested exceptions.
//  Returns the saved PC and mode on return-from-exception.
//  Sits beside the PC unit: pc_out feeds the RFE target mux; s_u_out restores the mode bit.
//  Fully synchronous to clk, unlike the edge-triggered IAR it replaces.
// PARAMETERS
//  WIDTH     32            PC width in bits
//  DEPTH     4             max nesting levels (>=1)
//  RESET_PC  32'h0001_0000 pc_out value while stack is empty / after reset
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      asynchronous, active-high reset
//  exception  in   1      1-cycle pulse: take exception, push
//  rfe        in   1      1-cycle pulse: return from exception, pop
//  memwrite   in   1      faulting instr is a store
//  oint_ex    in   1      interrupt raised in EX stage
//  trap       in   1      exception is a trap instruction
//  pc_8_in    in   WIDTH  PC+8 of the faulting instruction
//  s_u_in     in   1      current mode (1=user, 0=supervisor)
//  pc_out     out  WIDTH  saved PC at top of stack (RESET_PC when empty)
//  s_u_out    out  1      saved mode at top of stack (0 when empty)
//  level      out  $clog2(DEPTH+1)  number of valid entries
//  empty      out  1      level==0
//  full       out  1      level==DEPTH
//  overflow   out  1      sticky: push attempted while full
//  underflow  out  1      sticky: pop attempted while empty
// BEHAVIOUR
//  - Reset (async, any time incl. mid-nesting): level=0, all entries cleared,
//    pc_out=RESET_PC, s_u_out=0, overflow=underflow=0.
//  - trap_store = (memwrite & oint_ex) | trap (combinational).
//  - Saved PC = pc_8_in - 4 if trap_store else pc_8_in - 8, modulo 2^WIDTH (wrap, no flag).
//  - Push (exception=1, rfe=0, !full): entry[level] <= {saved PC, s_u_in}; level+1.
//    All outputs registered; new top visible the cycle after the pulse.
//  - Pop (rfe=1, exception=0, !empty): level-1; top reverts to the previous entry,
//    or to RESET_PC/0 if the stack becomes empty.
//  - exception & rfe same cycle, !empty: replace top in place; level unchanged.
//  - exception & rfe same cycle, empty: plain push, level=1; underflow not set.
//  - Push while full: stack and level unchanged; overflow <= 1.
//  - Pop while empty: no change; underflow <= 1.
//  - overflow and underflow are cleared only by reset.
//  - No mode gating: user/supervisor policy belongs to the caller.
//    The old "hold in user mode" rule is removed; exception must simply not pulse in user code paths.
//  - empty/full decode from the registered level; no combinational input->output path except none (all outputs flopped).
// STRUCTURE
//  - Shared package cpu_pkg: RESET_PC default, PC_WIDTH, entry struct {pc, s_u}, iar_adj_f() function (pc_8_in, trap_store -> saved PC).
//  - One sub-module natural: iar_lifo (generic DEPTH x W register LIFO with push/pop/replace, level, full/empty).
//  - iar_stack adds trap_store decode, PC adjustment, sticky error flags and empty-default muxing.
// TESTING
//  1. Reset with DEPTH=4 -> pc_out=0x0001_0000, level=0, empty=1, flags 0; assert reset mid-nest at level=3 -> same values immediately (async).
//  2. Exception pulse, trap=0, memwrite=0, pc_8_in=0x100, s_u_in=1 -> next cycle pc_out=0xF8, s_u_out=1, level=1.
//  3. Exception pulse, memwrite=1 & oint_ex=1, pc_8_in=0x200 -> pc_out=0x1FC.
//     Repeat with trap=1, pc_8_in=0x300 -> 0x2FC.
//  4. Nest 3 exceptions (pc_8_in 0x108, 0x208, 0x308, trap=0) then 3 rfe -> pc_out 0x300, 0x200, 0x100, then RESET_PC; empty=1.
//  5. Push 5 times at DEPTH=4 -> full=1, level=4, overflow=1, top unchanged from 4th push.
//     Then rfe on empty after draining -> underflow=1, pc_out=RESET_PC.
//  6. level=2, top=0x1F8; exception & rfe together with pc_8_in=0x408 -> top=0x400, level=2.
//     At empty, the same stimulus -> level=1, underflow=0.
//  7. pc_8_in=0x4, trap=0 -> pc_out=0xFFFF_FFFC (wrap).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the exception/return path: default restart PC,
// saved-entry layout and the restart-PC adjustment.
package cpu_pkg;

    localparam int PC_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0001_0000;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic                s_u;
    } iar_entry_t;

    // Stores and traps restart one instruction later than other faults.
    function automatic logic [PC_WIDTH-1:0] iar_adj_f(
        input logic [PC_WIDTH-1:0] pc_8,
        input logic                trap_store
    );
        return pc_8 - (trap_store ? PC_WIDTH'(4) : PC_WIDTH'(8));
    endfunction

endpackage

// File: rtl/iar_stack_lifo.sv
// Generic DEPTH x W register LIFO with push, pop and replace-top.
// Entry 0 is always the top; vacated slots are refilled with zero.
module iar_lifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  top,
    output logic [LW-1:0] level,
    output logic          empty,
    output logic          full
);

    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;
    logic         do_replace;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));
    assign top   = mem[0];

    // Simultaneous push and pop on an empty stack degenerates to a push.
    assign do_replace = push & pop & ~empty;
    assign do_push    = push & ~full & ~do_replace;
    assign do_pop     = pop & ~push & ~empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_replace) begin
            mem[0] <= din;
        end else if (do_push) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
            level <= level + LW'(1);
        end else if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
            mem[DEPTH-1] <= '0;
            level <= level - LW'(1);
        end
    end

endmodule

// File: rtl/iar_stack.sv
// Interrupt-address-register stack: saves restart PC and mode on each
// exception (nestable) and returns them on return-from-exception.
module iar_stack
    import cpu_pkg::*;
#(
    parameter int               WIDTH    = PC_WIDTH,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         exception,
    input  logic                         rfe,
    input  logic                         memwrite,
    input  logic                         oint_ex,
    input  logic                         trap,
    input  logic [WIDTH-1:0]             pc_8_in,
    input  logic                         s_u_in,
    output logic [WIDTH-1:0]             pc_out,
    output logic                         s_u_out,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);

    logic             trap_store;
    logic [WIDTH-1:0] saved_pc;
    logic [WIDTH:0]   top;

    assign trap_store = (memwrite & oint_ex) | trap;

    generate
        if (WIDTH == PC_WIDTH) begin : g_pkg_adj
            assign saved_pc = iar_adj_f(pc_8_in, trap_store);
        end else begin : g_local_adj
            assign saved_pc = pc_8_in - (trap_store ? WIDTH'(4) : WIDTH'(8));
        end
    endgenerate

    iar_lifo #(
        .W     (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk   (clk),
        .reset (reset),
        .push  (exception),
        .pop   (rfe),
        .din   ({saved_pc, s_u_in}),
        .top   (top),
        .level (level),
        .empty (empty),
        .full  (full)
    );

    // Empty slots hold zero, so only the PC needs the reset default.
    assign pc_out  = empty ? RESET_PC : top[WIDTH:1];
    assign s_u_out = top[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (exception & ~rfe & full)
                overflow <= 1'b1;
            if (rfe & ~exception & empty)
                underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_iar_stack.sv
// Self-checking bench for iar_stack: directed vector table, async reset
// sequence and randomized traffic against a queue-based reference model.
module tb_iar_stack;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] RPC = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        exception, rfe, memwrite, oint_ex, trap, s_u_in;
    logic [31:0] pc_8_in;
    logic [31:0] pc_out;
    logic        s_u_out;
    logic [2:0]  level;
    logic        empty, full, overflow, underflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iar_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk       (clk),
        .reset     (reset),
        .exception (exception),
        .rfe       (rfe),
        .memwrite  (memwrite),
        .oint_ex   (oint_ex),
        .trap      (trap),
        .pc_8_in   (pc_8_in),
        .s_u_in    (s_u_in),
        .pc_out    (pc_out),
        .s_u_out   (s_u_out),
        .level     (level),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    typedef struct {
        logic        exc, rf, mw, oi, tr, su;
        logic [31:0] pc8;
        logic [31:0] e_pc;
        logic        e_su;
        int          e_lvl;
        logic        e_ovf, e_unf;
    } vec_t;

    vec_t vecs[$];

    typedef struct {
        logic [31:0] pc;
        logic        su;
    } ent_t;

    ent_t model_q[$];
    logic m_ovf, m_unf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_su,
                             input int e_lvl, input logic e_ovf, input logic e_unf);
        check({tag, " pc_out"},    pc_out, e_pc);
        check({tag, " s_u_out"},   32'(s_u_out), 32'(e_su));
        check({tag, " level"},     32'(level), 32'(e_lvl));
        check({tag, " empty"},     32'(empty), 32'(e_lvl == 0));
        check({tag, " full"},      32'(full), 32'(e_lvl == DEPTH));
        check({tag, " overflow"},  32'(overflow), 32'(e_ovf));
        check({tag, " underflow"}, 32'(underflow), 32'(e_unf));
    endtask

    task automatic idle_inputs();
        exception = 0; rfe = 0; memwrite = 0; oint_ex = 0; trap = 0; s_u_in = 0; pc_8_in = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic void add(input logic exc, rf, mw, oi, tr, su, input logic [31:0] pc8,
                                input logic [31:0] e_pc, input logic e_su, input int e_lvl,
                                input logic e_ovf, input logic e_unf);
        vec_t v;
        v.exc = exc; v.rf = rf; v.mw = mw; v.oi = oi; v.tr = tr; v.su = su; v.pc8 = pc8;
        v.e_pc = e_pc; v.e_su = e_su; v.e_lvl = e_lvl; v.e_ovf = e_ovf; v.e_unf = e_unf;
        vecs.push_back(v);
    endfunction

    function automatic void model_step(input logic exc, rf, mw, oi, tr, su, input logic [31:0] pc8);
        ent_t e;
        logic ts;
        ts   = (mw & oi) | tr;
        e.pc = ts ? pc8 - 32'd4 : pc8 - 32'd8;
        e.su = su;
        if (exc && rf) begin
            if (model_q.size() > 0) model_q[model_q.size()-1] = e;
            else model_q.push_back(e);
        end else if (exc) begin
            if (model_q.size() == DEPTH) m_ovf = 1'b1;
            else model_q.push_back(e);
        end else if (rf) begin
            if (model_q.size() == 0) m_unf = 1'b1;
            else void'(model_q.pop_back());
        end
    endfunction

    initial begin
        idle_inputs();
        reset = 1'b1;
        #2;
        // Reset state before any clock edge (asynchronous).
        check_all("reset_init", RPC, 1'b0, 0, 1'b0, 1'b0);
        do_reset();
        check_all("after_reset", RPC, 1'b0, 0, 1'b0, 1'b0);

        //  exc rfe mw oi tr su pc8            e_pc          su lvl ovf unf
        add(1, 0, 0, 0, 0, 1, 32'h100,       32'hF8,        1, 1, 0, 0);
        add(1, 0, 1, 1, 0, 0, 32'h200,       32'h1FC,       0, 2, 0, 0);
        add(1, 0, 0, 0, 1, 1, 32'h300,       32'h2FC,       1, 3, 0, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0,         32'h1FC,       0, 2, 0, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0,         32'hF8,        1, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0,         RPC,           0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 32'h108,       32'h100,       0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 1, 32'h208,       32'h200,       1, 2, 0, 0);
        add(1, 0, 0, 0, 0, 0, 32'h308,       32'h300,       0, 3, 0, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0,         32'h200,       1, 2, 0, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0,         32'h100,       0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0,         RPC,           0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 32'h108,       32'h100,       0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 32'h200,       32'h1F8,       0, 2, 0, 0);
        add(1, 1, 0, 0, 0, 1, 32'h408,       32'h400,       1, 2, 0, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0,         32'h100,       0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0,         RPC,           0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 32'h408,       32'h400,       0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0,         RPC,           0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 32'h4,         32'hFFFF_FFFC, 1, 1, 0, 0);
        add(1, 0, 1, 0, 0, 0, 32'h10,        32'h8,         0, 2, 0, 0);
        add(1, 0, 0, 1, 0, 1, 32'h20,        32'h18,        1, 3, 0, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0,         32'h8,         0, 2, 0, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 1, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0,         RPC,           0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 32'h1008,      32'h1000,      0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 1, 32'h2008,      32'h2000,      1, 2, 0, 0);
        add(1, 0, 0, 0, 0, 0, 32'h3008,      32'h3000,      0, 3, 0, 0);
        add(1, 0, 0, 0, 0, 1, 32'h4008,      32'h4000,      1, 4, 0, 0);
        add(1, 0, 0, 0, 0, 0, 32'h5008,      32'h4000,      1, 4, 1, 0);
        add(1, 1, 0, 0, 0, 0, 32'h6008,      32'h6000,      0, 4, 1, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0,         32'h3000,      0, 3, 1, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0,         32'h2000,      1, 2, 1, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0,         32'h1000,      0, 1, 1, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0,         RPC,           0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 32'h0,         RPC,           0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1, 32'h0,         RPC,           0, 0, 1, 1);

        foreach (vecs[i]) begin
            exception = vecs[i].exc; rfe = vecs[i].rf; memwrite = vecs[i].mw;
            oint_ex = vecs[i].oi; trap = vecs[i].tr; s_u_in = vecs[i].su; pc_8_in = vecs[i].pc8;
            @(posedge clk); #1;
            idle_inputs();
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_su, vecs[i].e_lvl,
                      vecs[i].e_ovf, vecs[i].e_unf);
        end

        // Asynchronous reset mid-nest at level 3 clears everything without a clock edge.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            exception = 1; s_u_in = 1; pc_8_in = 32'h700 + 32'(k) * 32'h100;
            @(posedge clk); #1;
            idle_inputs();
        end
        check("nest3 level", 32'(level), 32'd3);
        check("nest3 pc_out", pc_out, 32'h8F8);
        #2 reset = 1'b1;
        #1;
        check_all("async_reset", RPC, 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic against the queue model.
        model_q.delete();
        m_ovf = 1'b0; m_unf = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic [31:0] r;
            r = $urandom_range(0, 99);
            exception = (r < 45);
            rfe       = (r >= 35 && r < 80);
            memwrite  = 1'($urandom);
            oint_ex   = 1'($urandom);
            trap      = ($urandom_range(0, 3) == 0);
            s_u_in    = 1'($urandom);
            pc_8_in   = $urandom;
            model_step(exception, rfe, memwrite, oint_ex, trap, s_u_in, pc_8_in);
            @(posedge clk); #1;
            idle_inputs();
            if (model_q.size() > 0)
                check_all($sformatf("rand%0d", n), model_q[model_q.size()-1].pc,
                          model_q[model_q.size()-1].su, model_q.size(), m_ovf, m_unf);
            else
                check_all($sformatf("rand%0d", n), RPC, 1'b0, 0, m_ovf, m_unf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
